// File: rtl/mult_parity_pkg.sv
// Shared types and helpers for the parity-protected signed multiplier.
// Parity helper is sized for the widest product so callers zero-extend narrower values.
package mult_parity_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int PARITY_MAX_W   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic parity(input logic [PARITY_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mult_parity_if.sv
// Request/acknowledge operand bus and result-strobe bus of the parity multiplier.
interface mult_parity_if
    import mult_parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);
    logic [DATA_W-1:0]   arg_a;
    logic [DATA_W-1:0]   arg_b;
    logic                arg_a_parity;
    logic                arg_b_parity;
    logic                req;
    logic                ack;
    logic [2*DATA_W-1:0] result;
    logic                result_parity;
    logic                result_rdy;
    logic                arg_parity_error;

    modport master (
        output arg_a, arg_b, arg_a_parity, arg_b_parity, req,
        input  ack, result, result_parity, result_rdy, arg_parity_error
    );

    modport slave (
        input  arg_a, arg_b, arg_a_parity, arg_b_parity, req,
        output ack, result, result_parity, result_rdy, arg_parity_error
    );

endinterface

// File: rtl/mult_parity_core.sv
// Combinational signed multiply, result parity and operand-error muxing.
// Operand parity ports exist only when MULT_PARITY_CHECK_EN is defined.
module mult_parity_core
    import mult_parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
`ifdef MULT_PARITY_CHECK_EN
    input  logic                a_par_i,
    input  logic                b_par_i,
`endif
    output logic [2*DATA_W-1:0] result_o,
    output logic                parity_o,
    output logic                err_o
);
    localparam int PW = 2 * DATA_W;

    logic [PW-1:0] a_ext_s;
    logic [PW-1:0] b_ext_s;
    logic [PW-1:0] prod_s;
    logic          err_s;

    // Sign-extending both operands makes the truncated product the exact signed result.
    assign a_ext_s = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    assign b_ext_s = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    assign prod_s  = a_ext_s * b_ext_s;

    // Parity check on the operands and suppression of the product on error.
    always_comb begin
        err_s = 1'b0;
`ifdef MULT_PARITY_CHECK_EN
        err_s = (parity({{(PARITY_MAX_W-DATA_W){1'b0}}, a_i}) != a_par_i) |
                (parity({{(PARITY_MAX_W-DATA_W){1'b0}}, b_i}) != b_par_i);
`endif
        if (err_s) begin
            result_o = {PW{1'b0}};
            parity_o = 1'b0;
        end else begin
            result_o = prod_s;
            parity_o = parity({{(PARITY_MAX_W-PW){1'b0}}, prod_s});
        end
        err_o = err_s;
    end

endmodule

// File: rtl/mult_parity_dut.sv
// Handshake FSM, operand capture and latency counter around mult_parity_core.
// Define MULT_PARITY_CHECK_EN to enable operand parity checking.
module mult_parity_dut
    import mult_parity_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    mult_parity_if.slave bus
);
    localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                ack_q;
    logic                rdy_q;
    logic [2*DATA_W-1:0] result_q;
    logic                rpar_q;
    logic                err_q;
    logic [2*DATA_W-1:0] result_d;
    logic                rpar_d;
    logic                err_d;
`ifdef MULT_PARITY_CHECK_EN
    logic                a_par_q;
    logic                b_par_q;
`endif

    mult_parity_core #(.DATA_W(DATA_W)) u_core (
        .a_i      (a_q),
        .b_i      (b_q),
`ifdef MULT_PARITY_CHECK_EN
        .a_par_i  (a_par_q),
        .b_par_i  (b_par_q),
`endif
        .result_o (result_d),
        .parity_o (rpar_d),
        .err_o    (err_d)
    );

    // Transaction FSM; rst_n is active high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            a_q      <= {DATA_W{1'b0}};
            b_q      <= {DATA_W{1'b0}};
            ack_q    <= 1'b0;
            rdy_q    <= 1'b0;
            result_q <= {(2*DATA_W){1'b0}};
            rpar_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef MULT_PARITY_CHECK_EN
            a_par_q  <= 1'b0;
            b_par_q  <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        a_q     <= bus.arg_a;
                        b_q     <= bus.arg_b;
`ifdef MULT_PARITY_CHECK_EN
                        a_par_q <= bus.arg_a_parity;
                        b_par_q <= bus.arg_b_parity;
`endif
                        ack_q   <= 1'b1;
                        cnt_q   <= CNT_LOAD;
                        state_q <= CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        result_q <= result_d;
                        rpar_q   <= rpar_d;
                        err_q    <= err_d;
                        rdy_q    <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack              = ack_q;
    assign bus.result_rdy       = rdy_q;
    assign bus.result           = result_q;
    assign bus.result_parity    = rpar_q;
    assign bus.arg_parity_error = err_q;

endmodule

// File: tb/tb_mult_parity_dut.sv
// Self-checking bench for mult_parity_dut: directed corner cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_mult_parity_dut;
    localparam int DATA_W  = 16;
    localparam int LATENCY = 2;
`ifdef MULT_PARITY_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mult_parity_if #(.DATA_W(DATA_W)) bus ();

    mult_parity_dut #(.DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed product in plain integer arithmetic, parity by bit count.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic pa, input logic pb,
                                  output logic [31:0] r, output logic rp, output logic e);
        int prod;
        bit bad;
        bad  = ((($countones(a) % 2) == 1) != pa) || ((($countones(b) % 2) == 1) != pb);
        prod = int'($signed(a)) * int'($signed(b));
        e    = CHECK_EN && bad;
        if (e) begin
            r  = 32'd0;
            rp = 1'b0;
        end else begin
            r  = prod;
            rp = ($countones(prod) % 2) == 1;
        end
    endfunction

    task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                           input logic pa, input logic pb, input string tag);
        logic [31:0] exp_r;
        logic        exp_p;
        logic        exp_e;
        bit          got_ack;
        @(posedge clk); #1;
        bus.arg_a        = a;
        bus.arg_b        = b;
        bus.arg_a_parity = pa;
        bus.arg_b_parity = pb;
        bus.req          = 1'b1;
        model(bus.arg_a, bus.arg_b, bus.arg_a_parity, bus.arg_b_parity, exp_r, exp_p, exp_e);
        got_ack = 1'b0;
        for (int i = 0; i < 8 && !got_ack; i++) begin
            @(posedge clk); #1;
            got_ack = bus.ack;
        end
        bus.req = 1'b0;
        if (!got_ack) begin
            chk({tag, ":ack_timeout"}, 64'd0, 64'd1);
            return;
        end
        chk({tag, ":rdy_at_ack"}, {63'd0, bus.result_rdy}, 64'd0);
        for (int n = 1; n <= LATENCY + 1; n++) begin
            @(posedge clk); #1;
            chk({tag, ":ack_width"}, {63'd0, bus.ack}, 64'd0);
            chk({tag, ":rdy"}, {63'd0, bus.result_rdy}, {63'd0, (n == LATENCY)});
            if (n >= LATENCY) begin
                chk({tag, ":result"}, {32'd0, bus.result}, {32'd0, exp_r});
                chk({tag, ":rparity"}, {63'd0, bus.result_parity}, {63'd0, exp_p});
                chk({tag, ":err"}, {63'd0, bus.arg_parity_error}, {63'd0, exp_e});
            end
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rpa;
        logic        rpb;
        bit          got_ack;
        n_checks         = 0;
        n_errors         = 0;
        rst_n            = 1'b1;
        bus.req          = 1'b0;
        bus.arg_a        = 16'd0;
        bus.arg_b        = 16'd0;
        bus.arg_a_parity = 1'b0;
        bus.arg_b_parity = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        chk("rst:ack", {63'd0, bus.ack}, 64'd0);
        chk("rst:rdy", {63'd0, bus.result_rdy}, 64'd0);
        chk("rst:result", {32'd0, bus.result}, 64'd0);
        chk("rst:err", {63'd0, bus.arg_parity_error}, 64'd0);

        run_txn(16'd3, 16'd4, 1'b0, 1'b1, "3x4");
        run_txn(16'hFFFF, 16'd1, 1'b0, 1'b1, "m1x1");
        run_txn(16'h8000, 16'h8000, 1'b1, 1'b1, "min_sq");
        run_txn(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, "max_sq");
        run_txn(16'd1, 16'd5, 1'b0, 1'b0, "bad_par_a");

        // Reset while the transaction is in CALC must suppress its strobe.
        @(posedge clk); #1;
        bus.arg_a        = 16'd7;
        bus.arg_b        = 16'd9;
        bus.arg_a_parity = 1'b1;
        bus.arg_b_parity = 1'b0;
        bus.req          = 1'b1;
        got_ack = 1'b0;
        for (int i = 0; i < 8 && !got_ack; i++) begin
            @(posedge clk); #1;
            got_ack = bus.ack;
        end
        bus.req = 1'b0;
        chk("abort:ack_seen", {63'd0, got_ack}, 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int n = 0; n < LATENCY + 3; n++) begin
            chk("abort:no_rdy", {63'd0, bus.result_rdy}, 64'd0);
            @(posedge clk); #1;
        end
        chk("abort:result_cleared", {32'd0, bus.result}, 64'd0);
        run_txn(16'd7, 16'd9, 1'b1, 1'b0, "after_abort");

        for (int t = 0; t < 20; t++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rpa = ^ra;
            rpb = ^rb;
            if ($urandom_range(3, 0) == 0) rpa = ~rpa;
            if ($urandom_range(3, 0) == 0) rpb = ~rpb;
            run_txn(ra, rb, rpa, rpb, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mult_parity_dut.md
Name:
mult_parity_dut

Overview:
- Signed 16x16 multiplier with even-parity protection on operands and result.
- Request/acknowledge handshake on the input side; one-cycle result-ready strobe on the output side.
- Stands as the DUT driven by the mult_bfm interface in the multiplier verification environment.

Parameters:
- DATA_W, 16: operand width; result width is 2*DATA_W.
- LATENCY, 2: cycles from the ack pulse to the result_rdy pulse; minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, ACTIVE-HIGH. The codebase name is kept even though the polarity is high.
- arg_a  in  DATA_W  operand A, two's complement signed.
- arg_b  in  DATA_W  operand B, two's complement signed.
- arg_a_parity  in  1  even-parity bit for arg_a; must equal XOR of all arg_a bits.
- arg_b_parity  in  1  even-parity bit for arg_b.
- req  in  1  request; held high by the master together with stable operands.
- ack  out  1  one-cycle pulse: operands captured.
- result  out  2*DATA_W  signed product.
- result_parity  out  1  XOR of all result bits.
- result_rdy  out  1  one-cycle pulse: result, result_parity and arg_parity_error are valid.
- arg_parity_error  out  1  operand parity mismatch detected for this transaction.

Behaviour:
- Synchronous reset while rst_n=1 at a rising edge:
  - all outputs go to 0; state goes to IDLE.
  - Reset aborts any transaction in flight; no result_rdy is produced for it.
- FSM states are IDLE, CALC, DONE.
- IDLE:
  - At a rising edge with req=1, capture arg_a, arg_b and both parity bits into registers.
  - Assert ack=1 for exactly that following cycle, then go to CALC and load the latency counter.
- CALC:
  - req is ignored; the master deasserts it after seeing ack. A req still high in CALC/DONE is not a new request.
  - The counter counts LATENCY-1 cycles. Then result outputs are registered, result_rdy=1 for one cycle, and the state goes to DONE.
- DONE:
  - Return to IDLE on the next edge.
  - A new request is accepted only when req=1 is sampled in IDLE. Back-to-back throughput is one transaction per LATENCY+2 cycles.
- Timing: req sampled at edge k means ack is high in cycle k..k+1 and result_rdy is high in cycle k+LATENCY..k+LATENCY+1.
- Parity check on the captured values: err = (^arg_a != arg_a_parity) | (^arg_b != arg_b_parity).
- Result with err=0:
  - result = $signed(arg_a) * $signed(arg_b), full 2*DATA_W width, no overflow possible.
  - result_parity = ^result.
  - arg_parity_error = 0.
- Result with err=1: result = 0, result_parity = 0, arg_parity_error = 1.
- result, result_parity and arg_parity_error hold their value after the strobe until the next result_rdy or a reset.
- ack and result_rdy are never high in the same cycle.

Optional Feature:
- Macro MULT_PARITY_CHECK_EN.
- Defined: operand parity is checked as above.
- Undefined:
  - arg_a_parity and arg_b_parity are ignored.
  - arg_parity_error is tied to 0.
  - The product is always computed; result_parity is still generated.

Decomposition:
- Package mult_parity_pkg holds:
  - DATA_W default.
  - state enum {IDLE, CALC, DONE}.
  - function parity(logic [N-1:0]) returning the XOR reduction.
- Sub-module mult_parity_core: purely combinational signed multiply, result-parity generation and error muxing. The top level holds the FSM, capture registers and counter.

Test Plan:
- Reset: rst_n=1 for 2 cycles, then 0 -> ack=0, result_rdy=0, result=0, arg_parity_error=0.
- arg_a=3, arg_b=4, correct parities (0,1), req held until ack:
  - ack exactly 1 cycle.
  - result_rdy LATENCY cycles later with result=12, result_parity=0, error=0.
- arg_a=16'hFFFF (-1), arg_b=1, parities 0/1 -> result=32'hFFFFFFFF, result_parity=0.
- arg_a=arg_b=16'h8000 -> result=32'h40000000, result_parity=1.
- arg_a=arg_b=16'h7FFF -> result=32'h3FFF0001, result_parity=1.
- arg_a=1 with arg_a_parity=0, arg_b=5 correct:
  - MULT_PARITY_CHECK_EN defined: arg_parity_error=1, result=0, result_parity=0.
  - Undefined: result=5.
- rst_n=1 during CALC -> no result_rdy; next request completes normally.
